// File: rtl/logic_unit_sched.sv
// Round-robin scheduler sharing one bitwise logic unit between two requesters.
// Optional grant counters are built when PERF_CNT_EN is defined.
module logic_unit_sched #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W      = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [2:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [2:0]         req1_op,
  output logic [WIDTH-1:0]   lu_a,
  output logic [WIDTH-1:0]   lu_b,
  input  logic [5*WIDTH-1:0] lu_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      state_r;
  logic [2:0]  op_r;
  logic        id_r;
  logic        last_id_r;
  logic [3:0]  settle_cnt_r;
  logic        accept_s;
  logic        win_id_s;
  logic [WIDTH:0] result_s;

  // Returns {err, data}: the selected result slice, or zero with err set for op codes 5..7.
  function automatic logic [WIDTH:0] select_result(input logic [2:0] op,
                                                   input logic [5*WIDTH-1:0] y);
    logic [WIDTH:0] r;
    case (op)
      3'd0:    r = {1'b0, y[0*WIDTH +: WIDTH]};
      3'd1:    r = {1'b0, y[1*WIDTH +: WIDTH]};
      3'd2:    r = {1'b0, y[2*WIDTH +: WIDTH]};
      3'd3:    r = {1'b0, y[3*WIDTH +: WIDTH]};
      3'd4:    r = {1'b0, y[4*WIDTH +: WIDTH]};
      default: r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_r == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || last_id_r);
      req1_ready = req1_valid && (!req0_valid || !last_id_r);
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign accept_s = req0_ready || req1_ready;
  assign win_id_s = req1_ready;
  assign result_s = select_result(op_r, lu_y);

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      op_r         <= 3'd0;
      id_r         <= 1'b0;
      last_id_r    <= 1'b1;
      settle_cnt_r <= 4'd0;
      lu_a         <= {WIDTH{1'b0}};
      lu_b         <= {WIDTH{1'b0}};
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= {WIDTH{1'b0}};
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r         <= win_id_s ? req1_op : req0_op;
            lu_a         <= win_id_s ? req1_a : req0_a;
            lu_b         <= win_id_s ? req1_b : req0_b;
            id_r         <= win_id_s;
            last_id_r    <= win_id_s;
            settle_cnt_r <= 4'd0;
            busy         <= 1'b1;
            state_r      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            rsp_data  <= result_s[WIDTH-1:0];
            rsp_err   <= result_s[WIDTH];
            rsp_id    <= id_r;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Saturating per-requester accept counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= {CNT_W{1'b0}};
      grant_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (req0_ready && grant_cnt0 != {CNT_W{1'b1}}) begin
        grant_cnt0 <= grant_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (req1_ready && grant_cnt1 != {CNT_W{1'b1}}) begin
        grant_cnt1 <= grant_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_sched.sv
// Directed self-checking bench for logic_unit_sched with a behavioural logic unit.
module tb_logic_unit_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [3:0]  lu_a, lu_b, rsp_data;
  logic [19:0] lu_y;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  int          checks = 0;
  int          errors = 0;

  // Stand-in logic unit: y1=a&b, y2=a|b, y3=a^b, y4=~a, y5=~b.
  assign lu_y = {~lu_b, ~lu_a, lu_a ^ lu_b, lu_a | lu_b, lu_a & lu_b};

  always #5 clk = ~clk;

`ifdef PERF_CNT_EN
  logic [1:0] grant_cnt0, grant_cnt1;
  logic_unit_sched #(.WIDTH(4), .SETTLE_CYC(1), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_y(lu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1));
`else
  logic_unit_sched #(.WIDTH(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_y(lu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy));
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_op = 3'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
    tick(); tick();
    check("rst_lu_a", 32'(lu_a), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err_id", 32'({rsp_err, rsp_id}), 32'h0);
    reset = 1'b0;
    tick();

    // Single op from requester 0, y3 = a^b
    req0_valid = 1'b1; req0_a = 4'b1010; req0_b = 4'b0101; req0_op = 3'd2;
    #1;
    check("t1_ready0", 32'({req0_ready, req1_ready}), 32'h2);
    tick();
    req0_valid = 1'b0;
    check("t1_drive_busy", 32'(busy), 32'h1);
    check("t1_lu_ab", 32'({lu_a, lu_b}), 32'hA5);
    check("t1_no_rsp_yet", 32'(rsp_valid), 32'h0);
    tick();
    check("t1_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'h4F);
    rsp_ready = 1'b1;
    tick();
    check("t1_done", 32'({rsp_valid, busy}), 32'h0);
    rsp_ready = 1'b0;

    // Illegal op from requester 1, then a held response
    req1_valid = 1'b1; req1_a = 4'b1100; req1_b = 4'b1010; req1_op = 3'd6;
    #1;
    check("t3_ready1", 32'({req0_ready, req1_ready}), 32'h1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("t3_err_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'h70);
    req0_valid = 1'b1; req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 3'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'h70);
      check("t4_hold_ready_busy", 32'({req0_ready, req1_ready, busy}), 32'h1);
    end
    rsp_ready = 1'b1;
    tick();
    check("t4_idle", 32'({rsp_valid, rsp_err, busy}), 32'h0);
    check("t4_ready0", 32'(req0_ready), 32'h1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("t3_next_legal", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'h45);
    tick();
    check("t4_rsp_gone", 32'(rsp_valid), 32'h0);
    check("hold_lu_ab", 32'({lu_a, lu_b}), 32'hCA);

    // Both requesters valid from reset with rsp_ready=1: grants alternate every 3 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 4'b1100; req1_b = 4'b1010; req1_op = 3'd1;
    #1;
    for (int k = 0; k < 12; k++) begin
      check("t2_ready0", 32'(req0_ready), 32'((k % 3 == 0) && ((k / 3) % 2 == 0)));
      check("t2_ready1", 32'(req1_ready), 32'((k % 3 == 0) && ((k / 3) % 2 == 1)));
      if (k % 3 == 2) begin
        if ((k / 3) % 2 == 0) check("t2_rsp0", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'h48);
        else                  check("t2_rsp1", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'h6E);
      end else begin
        check("t2_no_rsp", 32'(rsp_valid), 32'h0);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();

    // Reset during DRIVE discards the op
    req0_valid = 1'b1; req0_a = 4'b0110; req0_b = 4'b0011; req0_op = 3'd1;
    tick();
    req0_valid = 1'b0;
    check("t5_in_drive", 32'({busy, lu_a}), 32'h16);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_after_rst", 32'({rsp_valid, busy, lu_a}), 32'h0);
    tick();
    check("t5_no_rsp", 32'(rsp_valid), 32'h0);
    req1_valid = 1'b1; req1_a = 4'b1100; req1_b = 4'b1010; req1_op = 3'd3;
    tick();
    req1_valid = 1'b0;
    tick();
    check("t5_next_op", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'h63);
    tick();

`ifdef PERF_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0;
    for (int i = 0; i < 15; i++) tick();
    req0_valid = 1'b0;
    tick(); tick();
    check("t6_cnt0_sat", 32'(grant_cnt0), 32'h3);
    check("t6_cnt1", 32'(grant_cnt1), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
